// File: rtl/atomic_clock_sequencer.sv
// Master interrogation-cycle FSM: Q0 idle, Q1..Q8 timed dwell phases, Q9 one-cycle report.
// Optional completed-sequence counter compiled in with `define SEQ_CYCLE_COUNT_EN.
module atomic_clock_sequencer #(
  parameter int CNT_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             run_cont,
  input  logic             cfg_we,
  input  logic [3:0]       cfg_addr,
  input  logic [CNT_W-1:0] cfg_data,
  output logic [3:0]       state,
  output logic             busy,
  output logic             done
`ifdef SEQ_CYCLE_COUNT_EN
  ,
  output logic [15:0]      cycle_count
`endif
);

  typedef enum logic [3:0] {
    Q0 = 4'd0, Q1 = 4'd1, Q2 = 4'd2, Q3 = 4'd3, Q4 = 4'd4,
    Q5 = 4'd5, Q6 = 4'd6, Q7 = 4'd7, Q8 = 4'd8, Q9 = 4'd9
  } state_t;

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             busy_reg;
  logic             done_reg;

  // Effective dwell per state code; a programmed 0 behaves as 1, and
  // non-timed codes read as 1 so the lookup below can index with any code.
  logic [CNT_W-1:0] dwell_eff [0:15];

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_dwell
      if (gi >= 1 && gi <= 8) begin : g_reg
        logic [CNT_W-1:0] dwell_reg;
        always_ff @(posedge clk) begin
          if (rst) begin
            dwell_reg <= CNT_W'(1);
          end else if (cfg_we && cfg_addr == 4'(gi)) begin
            dwell_reg <= cfg_data;
          end
        end
        assign dwell_eff[gi] = (dwell_reg == '0) ? CNT_W'(1) : dwell_reg;
      end else begin : g_none
        assign dwell_eff[gi] = CNT_W'(1);
      end
    end
  endgenerate

  logic       expire;
  logic [3:0] state_inc;

  assign expire    = (cnt_reg <= CNT_W'(1));
  assign state_inc = 4'(state_reg) + 4'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= Q0;
      cnt_reg   <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else if (abort) begin
      state_reg <= Q0;
      cnt_reg   <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      case (state_reg)
        Q0: begin
          if (start) begin
            state_reg <= Q1;
            cnt_reg   <= dwell_eff[1];
            busy_reg  <= 1'b1;
          end
        end
        Q1, Q2, Q3, Q4, Q5, Q6, Q7, Q8: begin
          if (!expire) begin
            cnt_reg <= cnt_reg - CNT_W'(1);
          end else if (state_reg == Q8) begin
            state_reg <= Q9;
            cnt_reg   <= '0;
            done_reg  <= 1'b1;
          end else begin
            // Dwell is read on the entry edge, so a same-edge write is not yet visible.
            state_reg <= state_t'(state_inc);
            cnt_reg   <= dwell_eff[state_inc];
          end
        end
        Q9: begin
          done_reg <= 1'b0;
          if (run_cont) begin
            state_reg <= Q1;
            cnt_reg   <= dwell_eff[1];
          end else begin
            state_reg <= Q0;
            cnt_reg   <= '0;
            busy_reg  <= 1'b0;
          end
        end
        default: begin
          state_reg <= Q0;
          cnt_reg   <= '0;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign state = state_reg;
  assign busy  = busy_reg;
  assign done  = done_reg;

`ifdef SEQ_CYCLE_COUNT_EN
  logic [15:0] cycle_count_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_count_reg <= '0;
    end else if (!abort && state_reg == Q8 && expire) begin
      cycle_count_reg <= cycle_count_reg + 16'd1;
    end
  end

  assign cycle_count = cycle_count_reg;
`endif

endmodule

// File: tb/tb_atomic_clock_sequencer.sv
// Directed bench for atomic_clock_sequencer: expected state traces are built
// from a bench-side copy of the dwell register file.
module tb_atomic_clock_sequencer;

  localparam int CNT_W = 24;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic             run_cont = 1'b0;
  logic             cfg_we = 1'b0;
  logic [3:0]       cfg_addr = 4'd0;
  logic [CNT_W-1:0] cfg_data = '0;
  logic [3:0]       state;
  logic             busy;
  logic             done;
`ifdef SEQ_CYCLE_COUNT_EN
  logic [15:0]      cycle_count;
`endif

  int vectors = 0;
  int miscompares = 0;
  int md [1:8];

  atomic_clock_sequencer #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .run_cont(run_cont),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .state(state), .busy(busy), .done(done)
`ifdef SEQ_CYCLE_COUNT_EN
    , .cycle_count(cycle_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  task automatic write_dwell(input int addr, input int data);
    cfg_we   = 1'b1;
    cfg_addr = 4'(addr);
    cfg_data = CNT_W'(data);
    tick();
    cfg_we   = 1'b0;
    if (addr >= 1 && addr <= 8) md[addr] = data;
  endtask

  // Pulse start and follow the whole single-shot sequence against the model.
  task automatic check_seq(input string tag);
    int n;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      n = (md[k] == 0) ? 1 : md[k];
      for (int j = 0; j < n; j++) begin
        check_val($sformatf("%s_q%0d_c%0d", tag, k, j), 32'(state), 32'(k));
        check_val($sformatf("%s_busy", tag), 32'(busy), 32'd1);
        tick();
      end
    end
    check_val({tag, "_q9"}, 32'(state), 32'd9);
    check_val({tag, "_done"}, 32'(done), 32'd1);
    tick();
    check_val({tag, "_end_q0"}, 32'(state), 32'd0);
    check_val({tag, "_end_busy"}, 32'(busy), 32'd0);
    check_val({tag, "_end_done"}, 32'(done), 32'd0);
  endtask

  task automatic wait_state(input string tag, input int target, input int limit);
    for (int i = 0; i < limit && state != 4'(target); i++) tick();
    check_val(tag, 32'(state), 32'(target));
  endtask

  initial begin
    int dur;
    for (int k = 1; k <= 8; k++) md[k] = 1;

    // Reset held 3 cycles
    rst = 1'b1;
    repeat (3) tick();
    check_val("rst_state", 32'(state), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_done", 32'(done), 32'd0);
    rst = 1'b0;
    tick();
    check_val("idle_no_start", 32'(state), 32'd0);

    check_seq("dflt");

    // dwell[k] = k: Q9 at cycle 37, Q0 at 38
    for (int k = 1; k <= 8; k++) write_dwell(k, k);
    check_seq("prog");

    write_dwell(3, 0);
    check_seq("zero3");
    write_dwell(0, 5);
    write_dwell(12, 5);
    check_seq("badaddr");

    // Abort mid-dwell in Q5 (dwell 5)
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_state("ab5_reach", 5, 40);
    tick();
    check_val("ab5_mid", 32'(state), 32'd5);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_val("ab5_state", 32'(state), 32'd0);
    check_val("ab5_busy", 32'(busy), 32'd0);
    tick();
    check_val("ab5_stay", 32'(state), 32'd0);

    // start and abort together in Q0
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check_val("stab_state", 32'(state), 32'd0);
    check_val("stab_busy", 32'(busy), 32'd0);

    // Abort in Q9 wins over run_cont
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_state("ab9_reach", 9, 60);
    abort = 1'b1;
    run_cont = 1'b1;
    tick();
    abort = 1'b0;
    check_val("ab9_state", 32'(state), 32'd0);
    check_val("ab9_busy", 32'(busy), 32'd0);
    run_cont = 1'b0;

    // Continuous mode with a live dwell[4] rewrite during Q4
    write_dwell(4, 2);
    run_cont = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_state("cont_q4_reach", 4, 60);
    write_dwell(4, 10);
    check_val("live_q4_c1", 32'(state), 32'd4);
    tick();
    check_val("live_q4_exit", 32'(state), 32'd5);
    wait_state("cont_q9_reach", 9, 60);
    tick();
    check_val("cont_q1", 32'(state), 32'd1);
    check_val("cont_busy", 32'(busy), 32'd1);
    wait_state("cont2_q4_reach", 4, 60);
    dur = 0;
    for (int i = 0; i < 40 && state == 4'd4; i++) begin
      dur++;
      tick();
    end
    check_val("cont2_q4_len", 32'(dur), 32'd10);
    run_cont = 1'b0;
    wait_state("cont_stop", 0, 80);

`ifdef SEQ_CYCLE_COUNT_EN
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 1; k <= 8; k++) md[k] = 1;
    check_val("cc_rst", 32'(cycle_count), 32'd0);
    check_seq("cc1");
    check_seq("cc2");
    check_seq("cc3");
    check_val("cc_three", 32'(cycle_count), 32'd3);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_state("cc_ab_reach", 5, 20);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_val("cc_abort_keep", 32'(cycle_count), 32'd3);
    force dut.cycle_count_reg = 16'hFFFF;
    #1;
    release dut.cycle_count_reg;
    check_val("cc_preload", 32'(cycle_count), 32'hFFFF);
    check_seq("cc_wrap_seq");
    check_val("cc_wrap", 32'(cycle_count), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
